// File: rtl/dwc_pkg.sv
// Shared types for the DwC error monitor: FSM state encoding and
// consecutive-error counter width.
package dwc_pkg;

    // Encoding is visible on port_state, so values are fixed.
    typedef enum logic [1:0] {
        StOk      = 2'd0,
        StSuspect = 2'd1,
        StAlarm   = 2'd2
    } dwc_state_e;

    // Consecutive-error counter width; saturates at 15.
    localparam int unsigned CONSEC_WIDTH = 4;

endpackage

// File: rtl/dwc_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear beats increment, and
// the count sticks at all-ones instead of wrapping.
module dwc_sat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             port_clk,
    input  logic             port_rst,
    input  logic             port_clr,
    input  logic             port_inc,
    output logic [WIDTH-1:0] port_count
);

    // Count register: reset/clear to zero, otherwise saturating increment.
    always_ff @(posedge port_clk) begin
        if (port_rst || port_clr) begin
            port_count <= '0;
        end else if (port_inc && (port_count != {WIDTH{1'b1}})) begin
            port_count <= port_count + 1'b1;
        end
    end

endmodule

// File: rtl/dwc_error_monitor.sv
// DwC error monitor: masks erroneous samples, tracks consecutive and total
// faults, and raises a sticky alarm after THRESH consecutive errors.
// Optional macro DWC_MONITOR_LOG_EN adds a first-error data log.
module dwc_error_monitor
    import dwc_pkg::*;
#(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned THRESH    = 3,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 port_clk,
    input  logic                 port_rst,
    input  logic                 port_valid,
    input  logic [WIDTH-1:0]     port_in,
    input  logic                 port_error,
    input  logic                 port_ack,
    output logic [WIDTH-1:0]     port_out,
    output logic                 port_out_valid,
    output logic                 port_alarm,
    output logic [1:0]           port_state,
    output logic [CNT_WIDTH-1:0] port_fault_count
`ifdef DWC_MONITOR_LOG_EN
    ,
    output logic [WIDTH-1:0]     port_log_data,
    output logic                 port_log_valid
`endif
);

    localparam logic [CONSEC_WIDTH-1:0] THRESH_L = CONSEC_WIDTH'(THRESH);

    dwc_state_e              r_state;
    logic                    r_alarm;
    logic [WIDTH-1:0]        r_out;
    logic                    r_out_valid;
    logic [CONSEC_WIDTH-1:0] w_consec;
    logic [CONSEC_WIDTH-1:0] w_consec_inc;
    logic                    w_sample_err;
    logic                    w_sample_ok;
    logic                    w_ack;

    assign w_sample_err = port_valid & port_error;
    assign w_sample_ok  = port_valid & ~port_error;
    // Ack only counts while alarmed; elsewhere it is ignored.
    assign w_ack        = port_ack & (r_state == StAlarm);
    // Value the consecutive counter will hold after this erroneous sample.
    assign w_consec_inc = (w_consec == {CONSEC_WIDTH{1'b1}}) ? w_consec : w_consec + 1'b1;

    // Ack takes precedence over a concurrent error for the consecutive count.
    dwc_sat_counter #(
        .WIDTH (CONSEC_WIDTH)
    ) u_consec_cnt (
        .port_clk   (port_clk),
        .port_rst   (port_rst),
        .port_clr   (w_sample_ok | w_ack),
        .port_inc   (w_sample_err & ~w_ack),
        .port_count (w_consec)
    );

    // Total fault count is only ever cleared by reset.
    dwc_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_total_cnt (
        .port_clk   (port_clk),
        .port_rst   (port_rst),
        .port_clr   (1'b0),
        .port_inc   (w_sample_err),
        .port_count (port_fault_count)
    );

    // Health FSM with registered alarm output; ALARM holds until acked.
    always_ff @(posedge port_clk) begin
        if (port_rst) begin
            r_state <= StOk;
            r_alarm <= 1'b0;
        end else if (w_ack) begin
            r_state <= StOk;
            r_alarm <= 1'b0;
        end else begin
            unique case (r_state)
                StOk, StSuspect: begin
                    if (w_sample_err) begin
                        if (w_consec_inc >= THRESH_L) begin
                            r_state <= StAlarm;
                            r_alarm <= 1'b1;
                        end else begin
                            r_state <= StSuspect;
                        end
                    end else if (w_sample_ok) begin
                        r_state <= StOk;
                    end
                end
                StAlarm: begin
                    r_state <= StAlarm;
                    r_alarm <= 1'b1;
                end
                default: begin
                    r_state <= StOk;
                    r_alarm <= 1'b0;
                end
            endcase
        end
    end

    // Data path: pass clean samples, hold last good value on errors.
    always_ff @(posedge port_clk) begin
        if (port_rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_sample_ok;
            if (w_sample_ok) begin
                r_out <= port_in;
            end
        end
    end

    assign port_out       = r_out;
    assign port_out_valid = r_out_valid;
    assign port_alarm     = r_alarm;
    assign port_state     = r_state;

`ifdef DWC_MONITOR_LOG_EN
    logic [WIDTH-1:0] r_log_data;
    logic             r_log_valid;

    // Capture data of the first error since reset or the last ack.
    always_ff @(posedge port_clk) begin
        if (port_rst || w_ack) begin
            r_log_data  <= '0;
            r_log_valid <= 1'b0;
        end else if (w_sample_err && !r_log_valid) begin
            r_log_data  <= port_in;
            r_log_valid <= 1'b1;
        end
    end

    assign port_log_data  = r_log_data;
    assign port_log_valid = r_log_valid;
`endif

endmodule

// File: tb/tb_dwc_error_monitor.sv
// Directed self-checking bench for dwc_error_monitor. Main instance uses
// THRESH=3, CNT_WIDTH=2; a second instance covers THRESH=1 with WIDTH=4.
module tb_dwc_error_monitor;

    logic       port_clk = 1'b0;
    logic       port_rst = 1'b1;
    logic       port_valid = 1'b0;
    logic       port_in = 1'b0;
    logic       port_error = 1'b0;
    logic       port_ack = 1'b0;
    logic       port_out;
    logic       port_out_valid;
    logic       port_alarm;
    logic [1:0] port_state;
    logic [1:0] port_fault_count;

    logic [3:0] t1_in;
    logic [3:0] t1_out;
    logic       t1_out_valid;
    logic       t1_alarm;
    logic [1:0] t1_state;
    logic [7:0] t1_fault_count;

    int n_cmp = 0;
    int n_err = 0;

    assign t1_in = {3'b101, port_in};

    always #5 port_clk = ~port_clk;

`ifdef DWC_MONITOR_LOG_EN
    logic       port_log_data;
    logic       port_log_valid;
    logic [3:0] t1_log_data;
    logic       t1_log_valid;
`endif

    dwc_error_monitor #(
        .WIDTH     (1),
        .THRESH    (3),
        .CNT_WIDTH (2)
    ) u_dut (
        .port_clk         (port_clk),
        .port_rst         (port_rst),
        .port_valid       (port_valid),
        .port_in          (port_in),
        .port_error       (port_error),
        .port_ack         (port_ack),
        .port_out         (port_out),
        .port_out_valid   (port_out_valid),
        .port_alarm       (port_alarm),
        .port_state       (port_state),
        .port_fault_count (port_fault_count)
`ifdef DWC_MONITOR_LOG_EN
        ,
        .port_log_data    (port_log_data),
        .port_log_valid   (port_log_valid)
`endif
    );

    dwc_error_monitor #(
        .WIDTH     (4),
        .THRESH    (1),
        .CNT_WIDTH (8)
    ) u_dut_t1 (
        .port_clk         (port_clk),
        .port_rst         (port_rst),
        .port_valid       (port_valid),
        .port_in          (t1_in),
        .port_error       (port_error),
        .port_ack         (port_ack),
        .port_out         (t1_out),
        .port_out_valid   (t1_out_valid),
        .port_alarm       (t1_alarm),
        .port_state       (t1_state),
        .port_fault_count (t1_fault_count)
`ifdef DWC_MONITOR_LOG_EN
        ,
        .port_log_data    (t1_log_data),
        .port_log_valid   (t1_log_valid)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cycle(input logic v, input logic e, input logic d, input logic a);
        port_valid = v;
        port_error = e;
        port_in    = d;
        port_ack   = a;
        @(posedge port_clk);
        #1;
    endtask

    task automatic do_reset();
        port_rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        port_rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out"},   32'(port_out), 32'd0);
        check({tag, "_ov"},    32'(port_out_valid), 32'd0);
        check({tag, "_alarm"}, 32'(port_alarm), 32'd0);
        check({tag, "_state"}, 32'(port_state), 32'd0);
        check({tag, "_fc"},    32'(port_fault_count), 32'd0);
    endtask

    initial begin
        #2;
        do_reset();
        check_reset_vals("rst");
        check("rst_t1_fc", 32'(t1_fault_count), 32'd0);

        // Clean samples 1,0,1
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("clean1_out", 32'(port_out), 32'd1);
        check("clean1_ov", 32'(port_out_valid), 32'd1);
        check("clean1_t1_out", 32'(t1_out), 32'hb);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("clean0_out", 32'(port_out), 32'd0);
        check("clean0_ov", 32'(port_out_valid), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("clean2_out", 32'(port_out), 32'd1);
        check("clean2_state", 32'(port_state), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_ov", 32'(port_out_valid), 32'd0);
        check("idle_out", 32'(port_out), 32'd1);
        check("idle_fc", 32'(port_fault_count), 32'd0);

        // Single error then clean
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("err1_out_hold", 32'(port_out), 32'd1);
        check("err1_ov", 32'(port_out_valid), 32'd0);
        check("err1_state", 32'(port_state), 32'd1);
        check("err1_fc", 32'(port_fault_count), 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("rec_state", 32'(port_state), 32'd0);
        check("rec_out", 32'(port_out), 32'd0);
        check("rec_ov", 32'(port_out_valid), 32'd1);

        // Error without valid is ignored
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("noval_state", 32'(port_state), 32'd0);
        check("noval_fc", 32'(port_fault_count), 32'd1);
        check("noval_out", 32'(port_out), 32'd0);

        // Ack outside ALARM does nothing
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("ackok_state", 32'(port_state), 32'd1);
        check("ackok_fc", 32'(port_fault_count), 32'd2);

        // Three consecutive errors raise ALARM
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("t1_first_err_state", 32'(t1_state), 32'd2);
        check("t1_first_err_alarm", 32'(t1_alarm), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("e2_state", 32'(port_state), 32'd1);
        check("e2_alarm", 32'(port_alarm), 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("e3_state", 32'(port_state), 32'd2);
        check("e3_alarm", 32'(port_alarm), 32'd1);
        check("e3_fc", 32'(port_fault_count), 32'd3);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("alarm_clean_state", 32'(port_state), 32'd2);
        check("alarm_clean_out", 32'(port_out), 32'd1);
        check("alarm_clean_ov", 32'(port_out_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("ack_state", 32'(port_state), 32'd0);
        check("ack_alarm", 32'(port_alarm), 32'd0);
        check("ack_fc", 32'(port_fault_count), 32'd3);

        // Saturation and ack concurrent with an error
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("sat_fc", 32'(port_fault_count), 32'd3);
        check("sat_state", 32'(port_state), 32'd2);
        check("sat_t1_fc", 32'(t1_fault_count), 32'd5);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check("ackerr_state", 32'(port_state), 32'd0);
        check("ackerr_alarm", 32'(port_alarm), 32'd0);
        check("ackerr_fc", 32'(port_fault_count), 32'd3);
        check("ackerr_t1_fc", 32'(t1_fault_count), 32'd6);
        check("ackerr_t1_state", 32'(t1_state), 32'd0);
        // Consecutive count must have been cleared by the ack
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_ack_e1_state", 32'(port_state), 32'd1);
        check("post_ack_t1_state", 32'(t1_state), 32'd2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_ack_e2_state", 32'(port_state), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_ack_e3_state", 32'(port_state), 32'd2);

        // Reset wins over valid and ack mid-ALARM
        port_rst = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        port_rst = 1'b0;
        check_reset_vals("midrst");

`ifdef DWC_MONITOR_LOG_EN
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("log_first_data", 32'(port_log_data), 32'd1);
        check("log_first_valid", 32'(port_log_valid), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("log_hold_data", 32'(port_log_data), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("log_alarm", 32'(port_alarm), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("log_ack_valid", 32'(port_log_valid), 32'd0);
        check("log_ack_data", 32'(port_log_data), 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("log_recap_data", 32'(port_log_data), 32'd1);
        check("log_recap_valid", 32'(port_log_valid), 32'd1);
        port_rst = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        port_rst = 1'b0;
        check("log_rst_valid", 32'(port_log_valid), 32'd0);
        check_reset_vals("logrst");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
